// File: rtl/m_axil_write_seq.sv
// AXI4-Lite write master: round-robin arbitration over NUM_REQ register-write requesters.
// Optional retry on SLVERR/DECERR responses is enabled by defining AXIL_WR_RETRY_EN.
module m_axil_write_seq #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_REQ   = 8,
  parameter int OFF_W     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*OFF_W-1:0]   req_off,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [1:0]                 req_resp,
  output logic                       busy,
  output logic [ADDR_W-1:0]          M_AXI_AWADDR,
  output logic                       M_AXI_AWVALID,
  input  logic                       M_AXI_AWREADY,
  output logic [DATA_W-1:0]          M_AXI_WDATA,
  output logic [DATA_W/8-1:0]        M_AXI_WSTRB,
  output logic                       M_AXI_WVALID,
  input  logic                       M_AXI_WREADY,
  input  logic [1:0]                 M_AXI_BRESP,
  input  logic                       M_AXI_BVALID,
  output logic                       M_AXI_BREADY
);

  localparam int GNT_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || OFF_W > ADDR_W || (DATA_W % 8) != 0 || MAX_RETRY < 1) begin : g_paramCheck
    $error("m_axil_write_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [GNT_W-1:0]   r_gnt;
  logic [GNT_W-1:0]   r_rrLast;
  logic               r_awPend;
  logic               r_wPend;
  logic [ADDR_W-1:0]  r_awAddr;
  logic [DATA_W-1:0]  r_wData;
  logic [1:0]         r_resp;
  logic [GNT_W-1:0]   w_gnt;
  logic               w_anyReq;
  logic               w_awFire;
  logic               w_wFire;
  logic               w_issueDone;
  logic               w_retry;

  // Scan downwards so the slot closest after rr_last is the last (winning) assignment.
  function automatic logic [GNT_W-1:0] nextGrant(input logic [NUM_REQ-1:0] valid,
                                                 input logic [GNT_W-1:0]   last);
    int idx;
    nextGrant = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid[idx[GNT_W-1:0]]) nextGrant = idx[GNT_W-1:0];
    end
  endfunction

  assign w_gnt       = nextGrant(req_valid, r_rrLast);
  assign w_anyReq    = |req_valid;
  assign w_awFire    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_wFire     = M_AXI_WVALID && M_AXI_WREADY;
  assign w_issueDone = (!r_awPend || M_AXI_AWREADY) && (!r_wPend || M_AXI_WREADY);

`ifdef AXIL_WR_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] r_retryCnt;

  assign w_retry = (r_state == RESP) && M_AXI_BVALID && M_AXI_BRESP[1] &&
                   (r_retryCnt < RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retryCnt <= '0;
    end else if (r_state == IDLE && w_anyReq) begin
      r_retryCnt <= '0;
    end else if (w_retry) begin
      r_retryCnt <= r_retryCnt + 1'b1;
    end
  end
`else
  assign w_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ISSUE;
      ISSUE:   if (w_issueDone) w_nextState = RESP;
      RESP:    if (M_AXI_BVALID) w_nextState = w_retry ? ISSUE : DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Address/data are captured once at grant so later requester changes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt    <= '0;
      r_rrLast <= GNT_W'(NUM_REQ - 1);
      r_awPend <= 1'b0;
      r_wPend  <= 1'b0;
      r_awAddr <= '0;
      r_wData  <= '0;
      r_resp   <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_gnt    <= w_gnt;
            r_rrLast <= w_gnt;
            r_awAddr <= base_addr + ADDR_W'(req_off[int'(w_gnt)*OFF_W +: OFF_W]);
            r_wData  <= req_data[int'(w_gnt)*DATA_W +: DATA_W];
            r_awPend <= 1'b1;
            r_wPend  <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_awFire) r_awPend <= 1'b0;
          if (w_wFire)  r_wPend  <= 1'b0;
        end
        RESP: begin
          if (M_AXI_BVALID) begin
            r_resp <= M_AXI_BRESP;
            if (w_retry) begin
              r_awPend <= 1'b1;
              r_wPend  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != IDLE);
    M_AXI_AWVALID = (r_state == ISSUE) && r_awPend;
    M_AXI_WVALID  = (r_state == ISSUE) && r_wPend;
    M_AXI_BREADY  = (r_state == RESP);
    req_done      = '0;
    req_resp      = 2'b00;
    if (r_state == DONE) begin
      req_done = NUM_REQ'(1) << r_gnt;
      req_resp = r_resp;
    end
  end

  assign M_AXI_AWADDR = r_awAddr;
  assign M_AXI_WDATA  = r_wData;
  assign M_AXI_WSTRB  = '1;

endmodule

// File: tb/tb_m_axil_write_seq.sv
// Directed self-checking bench for m_axil_write_seq with a small AXI-Lite slave model.
// Retry expectations follow AXIL_WR_RETRY_EN when defined for the build.
module tb_m_axil_write_seq;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 8;
  localparam int OFF_W   = 8;

  logic                      clk;
  logic                      reset;
  logic [ADDR_W-1:0]         base_addr;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*OFF_W-1:0]  req_off;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_done;
  logic [1:0]                req_resp;
  logic                      busy;
  logic [ADDR_W-1:0]         awAddr;
  logic                      awValid;
  logic                      awReady;
  logic [DATA_W-1:0]         wData;
  logic [DATA_W/8-1:0]       wStrb;
  logic                      wValid;
  logic                      wReady;
  logic [1:0]                bResp;
  logic                      bValid;
  logic                      bReady;

  int checks = 0;
  int failures = 0;

  int awDelay = 0;
  int wDelay = 0;
  int errFirst = 0;
  int awWait, wWait, bIssued, awBeats, wBeats;
  logic awGot, wGot;
  logic [ADDR_W-1:0] lastAw;
  logic [DATA_W-1:0] lastW;

  m_axil_write_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REQ(NUM_REQ), .OFF_W(OFF_W), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .req_valid(req_valid),
    .req_off(req_off), .req_data(req_data), .req_done(req_done), .req_resp(req_resp),
    .busy(busy), .M_AXI_AWADDR(awAddr), .M_AXI_AWVALID(awValid), .M_AXI_AWREADY(awReady),
    .M_AXI_WDATA(wData), .M_AXI_WSTRB(wStrb), .M_AXI_WVALID(wValid), .M_AXI_WREADY(wReady),
    .M_AXI_BRESP(bResp), .M_AXI_BVALID(bValid), .M_AXI_BREADY(bReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign awReady = (awWait >= awDelay);
  assign wReady  = (wWait >= wDelay);

  // Slave model: ready after a programmable number of valid cycles, B one cycle after both beats.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      awWait <= 0; wWait <= 0; awGot <= 1'b0; wGot <= 1'b0;
      bValid <= 1'b0; bResp <= 2'b00; bIssued <= 0;
      awBeats <= 0; wBeats <= 0; lastAw <= '0; lastW <= '0;
    end else begin
      if (awValid && awReady) begin
        awWait <= 0; awBeats <= awBeats + 1; lastAw <= awAddr;
      end else if (awValid) awWait <= awWait + 1;
      if (wValid && wReady) begin
        wWait <= 0; wBeats <= wBeats + 1; lastW <= wData;
      end else if (wValid) wWait <= wWait + 1;
      if (bValid && bReady) begin
        bValid <= 1'b0;
      end else if (!bValid && (awGot || (awValid && awReady)) && (wGot || (wValid && wReady))) begin
        bValid  <= 1'b1;
        bResp   <= (bIssued < errFirst) ? 2'b10 : 2'b00;
        bIssued <= bIssued + 1;
        awGot   <= 1'b0;
        wGot    <= 1'b0;
      end else begin
        if (awValid && awReady) awGot <= 1'b1;
        if (wValid && wReady)   wGot  <= 1'b1;
      end
    end
  end

  task automatic setSlot(input int slot, input logic [OFF_W-1:0] off, input logic [DATA_W-1:0] data);
    req_off[slot*OFF_W +: OFF_W]    = off;
    req_data[slot*DATA_W +: DATA_W] = data;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) for a done pulse, tallying handshake activity along the way.
  task automatic waitDone(input int maxCycles, output int cycles, output logic [NUM_REQ-1:0] doneVec,
                          output logic [1:0] resp, output int awCyc, output int wCyc, output int bEarly);
    cycles = 0; doneVec = '0; resp = 2'b00; awCyc = 0; wCyc = 0; bEarly = 0;
    while (doneVec == '0 && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
      if (awValid) awCyc++;
      if (wValid) wCyc++;
      if (bReady && (awValid || wValid)) bEarly++;
      if (req_done != '0) begin
        doneVec = req_done;
        resp    = req_resp;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    base_addr = '0; req_valid = '0; req_off = '0; req_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (awValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_awvalid: got %b expected 0", awValid); end
    checks++; if (wValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wvalid: got %b expected 0", wValid); end
    checks++; if (bReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_bready: got %b expected 0", bReady); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (req_done !== 8'h00) begin failures++; $display("[TB] FAIL reset_done: got %h expected 00", req_done); end
    checks++; if (req_resp !== 2'b00) begin failures++; $display("[TB] FAIL reset_resp: got %b expected 00", req_resp); end
    checks++; if (awAddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_awaddr: got %h expected 0", awAddr); end
    checks++; if (wData !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata: got %h expected 0", wData); end
    checks++; if (wStrb !== 4'hF) begin failures++; $display("[TB] FAIL reset_wstrb: got %h expected f", wStrb); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc, awc, wc, be;
    logic [NUM_REQ-1:0] dv;
    logic [1:0] rs;
    awDelay = 0; wDelay = 0;
    base_addr = 32'h4000_0000;
    setSlot(2, 8'h18, 32'h0000_00A5);
    req_valid = 8'h04;
    @(negedge clk);
    checks++; if (awValid !== 1'b1 || wValid !== 1'b1) begin failures++; $display("[TB] FAIL single_valids: got aw=%b w=%b expected 1 1", awValid, wValid); end
    checks++; if (awAddr !== 32'h4000_0018) begin failures++; $display("[TB] FAIL single_awaddr: got %h expected 40000018", awAddr); end
    checks++; if (wData !== 32'h0000_00A5) begin failures++; $display("[TB] FAIL single_wdata: got %h expected 000000a5", wData); end
    waitDone(50, cyc, dv, rs, awc, wc, be);
    req_valid = 8'h00;
    checks++; if (dv !== 8'h04) begin failures++; $display("[TB] FAIL single_done: got %h expected 04", dv); end
    checks++; if (rs !== 2'b00) begin failures++; $display("[TB] FAIL single_resp: got %b expected 00", rs); end
    // Grant cycle + the ISSUE cycle sampled above + waitDone cycles.
    checks++; if (cyc + 2 !== 4) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 4", cyc + 2); end
    checks++; if (be !== 0) begin failures++; $display("[TB] FAIL single_bready_early: got %0d expected 0", be); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_done !== 8'h00) begin failures++; $display("[TB] FAIL single_idle: got busy=%b done=%h expected 0 00", busy, req_done); end
  endtask

  task automatic test_handshake_delay();
    int cyc, awc, wc, be, beats0;
    logic [NUM_REQ-1:0] dv;
    logic [1:0] rs;
    awDelay = 2; wDelay = 0;
    beats0 = awBeats;
    setSlot(6, 8'h40, 32'h6666_0006);
    req_valid = 8'h40;
    @(negedge clk);
    checks++; if (bReady !== 1'b0) begin failures++; $display("[TB] FAIL delay_bready_issue: got %b expected 0", bReady); end
    req_valid = 8'h00;
    waitDone(50, cyc, dv, rs, awc, wc, be);
    checks++; if (awc + 1 !== 3) begin failures++; $display("[TB] FAIL delay_awvalid_cycles: got %0d expected 3", awc + 1); end
    checks++; if (wc + 1 !== 1) begin failures++; $display("[TB] FAIL delay_wvalid_cycles: got %0d expected 1", wc + 1); end
    checks++; if (be !== 0) begin failures++; $display("[TB] FAIL delay_bready_early: got %0d expected 0", be); end
    checks++; if (dv !== 8'h40) begin failures++; $display("[TB] FAIL delay_done_after_drop: got %h expected 40", dv); end
    checks++; if (cyc !== 4) begin failures++; $display("[TB] FAIL delay_latency: got %0d expected 4", cyc); end
    checks++; if (awBeats - beats0 !== 1) begin failures++; $display("[TB] FAIL delay_aw_beats: got %0d expected 1", awBeats - beats0); end
    awDelay = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] order[$];
    logic [NUM_REQ-1:0] expVec;
    doReset();
    base_addr = 32'h1000_0000;
    for (int i = 0; i < NUM_REQ; i++) setSlot(i, 8'(i * 4), 32'h100 + i);
    req_valid = 8'hFF;
    for (int c = 0; c < 400 && order.size() < 9; c++) begin
      @(negedge clk);
      if (req_done != '0) order.push_back(req_done);
    end
    req_valid = 8'h00;
    checks++; if (order.size() !== 9) begin failures++; $display("[TB] FAIL rr_count: got %0d expected 9", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      expVec = 8'(1) << (k % NUM_REQ);
      checks++; if (order[k] !== expVec) begin failures++; $display("[TB] FAIL rr_order[%0d]: got %h expected %h", k, order[k], expVec); end
    end
    checks++; if (lastAw !== 32'h1000_0000 || lastW !== 32'h100) begin failures++; $display("[TB] FAIL rr_last_beat: got %h/%h expected 10000000/00000100", lastAw, lastW); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int cyc, awc, wc, be;
    logic [NUM_REQ-1:0] dv;
    logic [1:0] rs;
    base_addr = 32'hFFFF_FFF0;
    setSlot(0, 8'h20, 32'hCAFE_0000);
    req_valid = 8'h01;
    @(negedge clk);
    checks++; if (awAddr !== 32'h0000_0010) begin failures++; $display("[TB] FAIL wrap_awaddr: got %h expected 00000010", awAddr); end
    base_addr = 32'h1234_5678;
    setSlot(0, 8'h04, 32'h0000_DEAD);
    req_valid = 8'h00;
    waitDone(50, cyc, dv, rs, awc, wc, be);
    checks++; if (dv !== 8'h01) begin failures++; $display("[TB] FAIL wrap_done: got %h expected 01", dv); end
    checks++; if (lastAw !== 32'h0000_0010) begin failures++; $display("[TB] FAIL wrap_stable_addr: got %h expected 00000010", lastAw); end
    checks++; if (lastW !== 32'hCAFE_0000) begin failures++; $display("[TB] FAIL wrap_stable_data: got %h expected cafe0000", lastW); end
    @(negedge clk);
  endtask

  task automatic test_retry();
    int cyc, awc, wc, be, expBeats;
    logic [NUM_REQ-1:0] dv;
    logic [1:0] rs, expResp;
`ifdef AXIL_WR_RETRY_EN
    expBeats = 2; expResp = 2'b00;
`else
    expBeats = 1; expResp = 2'b10;
`endif
    doReset();
    errFirst = 1;
    base_addr = 32'h2000_0000;
    setSlot(3, 8'h0C, 32'h3333_0003);
    req_valid = 8'h08;
    waitDone(100, cyc, dv, rs, awc, wc, be);
    req_valid = 8'h00;
    checks++; if (dv !== 8'h08) begin failures++; $display("[TB] FAIL retry_done: got %h expected 08", dv); end
    checks++; if (rs !== expResp) begin failures++; $display("[TB] FAIL retry_resp: got %b expected %b", rs, expResp); end
    checks++; if (awBeats !== expBeats) begin failures++; $display("[TB] FAIL retry_aw_beats: got %0d expected %0d", awBeats, expBeats); end
    checks++; if (wBeats !== expBeats) begin failures++; $display("[TB] FAIL retry_w_beats: got %0d expected %0d", wBeats, expBeats); end
    errFirst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, awc, wc, be, spurious;
    logic [NUM_REQ-1:0] dv;
    logic [1:0] rs;
    awDelay = 20;
    setSlot(5, 8'h14, 32'h5555_0005);
    setSlot(0, 8'h00, 32'h1111_0000);
    req_valid = 8'h20;
    @(negedge clk);
    checks++; if (awValid !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_issue: got %b expected 1", awValid); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (awValid !== 1'b0 || wValid !== 1'b0 || bReady !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_drop: got aw=%b w=%b b=%b expected 0 0 0", awValid, wValid, bReady); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_done != '0) spurious++;
    end
    awDelay = 0;
    reset = 1'b1;
    req_valid = 8'h21;
    waitDone(50, cyc, dv, rs, awc, wc, be);
    req_valid = 8'h20;
    checks++; if (dv !== 8'h01) begin failures++; $display("[TB] FAIL mid_slot0_priority: got %h expected 01", dv); end
    checks++; if (lastW !== 32'h1111_0000) begin failures++; $display("[TB] FAIL mid_slot0_data: got %h expected 11110000", lastW); end
    waitDone(50, cyc, dv, rs, awc, wc, be);
    req_valid = 8'h00;
    checks++; if (dv !== 8'h20) begin failures++; $display("[TB] FAIL mid_slot5_next: got %h expected 20", dv); end
    checks++; if (spurious !== 0) begin failures++; $display("[TB] FAIL mid_no_done_in_reset: got %0d expected 0", spurious); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_handshake_delay();
    test_back_to_back();
    test_wrap();
    test_retry();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
